// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the pipelined MIPS core.
// Owns the PC, which drives the instruction memory directly. It captures the
// returned instruction and PC+4 into the IF/ID register, and handles the
// hazard stall and the ID-stage redirect, which flushes IF/ID.
// Optional build macro IF_FETCH_PERF_EN adds saturating fetch, stall and
// flush counters on perf_fetched, perf_stalls and perf_flushes.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
`endif
);

  logic [31:0] pc_plus4;

  // Sequential fetch address; wraps mod 2^32 with no error indication.
  always_comb begin
    pc_plus4 = pc + 32'd4;
  end

  // PC and IF/ID register: stall holds, redirect flushes, otherwise fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (stall) begin
      pc          <= pc;
      if_id_instr <= if_id_instr;
      if_id_pc4   <= if_id_pc4;
      if_id_valid <= if_id_valid;
    end else if (br_taken) begin
      pc          <= {br_target[31:2], 2'b00};
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      pc          <= pc_plus4;
      if_id_instr <= instruction;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

`ifdef IF_FETCH_PERF_EN
  // Saturating event counters, one per per-edge action class.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else if (stall) begin
      if (perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end else if (br_taken) begin
      if (perf_flushes != '1) perf_flushes <= perf_flushes + 32'd1;
    end else begin
      if (perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by
// randomized stall/redirect/reset traffic, compared against a reference model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;
`endif

  logic [31:0] mem [256];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  longint unsigned m_fetched, m_stalls, m_flushes;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .instruction (instruction),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  // Combinational instruction memory: word address pc>>2 over 256 words.
  assign instruction = mem[pc[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] sat(input longint unsigned v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pc"},    pc,          m_pc);
    check({tag, ".instr"}, if_id_instr, m_instr);
    check({tag, ".pc4"},   if_id_pc4,   m_pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
`ifdef IF_FETCH_PERF_EN
    check({tag, ".pfetch"}, perf_fetched, sat(m_fetched));
    check({tag, ".pstall"}, perf_stalls,  sat(m_stalls));
    check({tag, ".pflush"}, perf_flushes, sat(m_flushes));
`endif
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_fetched = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // Drive one cycle's inputs, advance past the edge, update model, compare.
  task automatic cycle(input string tag, input logic s, input logic b, input logic [31:0] t);
    logic [31:0] fetched;
    stall = s; br_taken = b; br_target = t;
    fetched = mem[m_pc[9:2]];
    @(posedge clk);
    #1;
    if (s) begin
      m_stalls++;
    end else if (b) begin
      m_pc = t & ~32'd3;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_flushes++;
    end else begin
      m_pc = m_pc + 32'd4;
      m_instr = fetched; m_pc4 = m_pc; m_valid = 1'b1;
      m_fetched++;
    end
    check_all(tag);
  endtask

  // Assert reset between edges, check it acts immediately, hold for n edges.
  task automatic async_reset(input string tag, input int unsigned n);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_all({tag, ".held"});
    end
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i * 16 + 1;
    stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("reset0");
    @(posedge clk); #1; check_all("reset1");
    @(posedge clk); #1; check_all("reset2");
    rst = 1'b1;

    // Sequential fetch: pc 4,8,12; IF/ID 1,17,33 with pc4 4,8,12
    cycle("seq", 1'b0, 1'b0, 32'h0);
    check("seq.instr1", if_id_instr, 32'd1);
    cycle("seq", 1'b0, 1'b0, 32'h0);
    cycle("seq", 1'b0, 1'b0, 32'h0);
    check("seq.instr33", if_id_instr, 32'd33);
    check("seq.pc12", pc, 32'd12);

    // Stall hold at pc=12 for 3 cycles, then release
    for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b0, 32'h0);
    check("stall.pc12", pc, 32'd12);
    cycle("unstall", 1'b0, 1'b0, 32'h0);
    check("unstall.pc16", pc, 32'd16);
    check("unstall.pc4", if_id_pc4, 32'd16);

    // Redirect at pc=20 to unaligned 0xBE
    cycle("seq", 1'b0, 1'b0, 32'h0);
    cycle("redir", 1'b0, 1'b1, 32'h0000_00BE);
    check("redir.pcBC", pc, 32'hBC);
    cycle("redir.next", 1'b0, 1'b0, 32'h0);
    check("redir.pc4C0", if_id_pc4, 32'hC0);

    // Stall beats branch at pc=40
    cycle("to40", 1'b0, 1'b1, 32'd40);
    cycle("sb.stall", 1'b1, 1'b1, 32'h300);
    check("sb.pc40", pc, 32'd40);
    cycle("sb.take", 1'b0, 1'b1, 32'h300);
    check("sb.pc300", pc, 32'h300);

    // Back-to-back redirects and the JMP -1 idle loop
    cycle("b2b", 1'b0, 1'b1, 32'h44);
    cycle("b2b", 1'b0, 1'b1, 32'h81);
    for (int i = 0; i < 4; i++) begin
      cycle("idle.fetch", 1'b0, 1'b0, 32'h0);
      cycle("idle.jmp", 1'b0, 1'b1, m_pc - 32'd4);
    end

    // Async reset mid-operation at pc=0x100, during a stall
    cycle("to100", 1'b0, 1'b1, 32'h100);
    stall = 1'b1;
    async_reset("rst100", 1);
    stall = 1'b0;
    cycle("postrst", 1'b0, 1'b0, 32'h0);

    // PC wrap: redirect to 0xFFFF_FFFC, then one fetch
    async_reset("prewrap", 0);
    cycle("wrap.redir", 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle("wrap.fetch", 1'b0, 1'b0, 32'h0);
    check("wrap.pc0", pc, 32'h0);
    check("wrap.pc4", if_id_pc4, 32'h0);

    // Randomized traffic over random memory contents
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd.rst", $urandom_range(0, 2));
      end else begin
        cycle("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the program counter and drives it to the instruction memory, which decodes address PC>>2 over 256 words with a combinational read.
- Captures the returned 32-bit instruction, plus PC+4, into the IF/ID pipeline register that feeds decode.
- Handles the hazard-unit stall and the ID-stage branch/jump redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_WORD, 32'h0000_0000: word inserted into IF/ID on flush and on reset (all-zero is the core's NOP).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-low.
- stall  in  1  hazard-unit stall; holds the PC and IF/ID.
- br_taken  in  1  ID-stage redirect (taken BEZ/BNE or JMP).
- br_target  in  32  redirect byte address from ID.
- instruction  in  32  instruction word from the instruction memory for the current pc.
- pc  out  32  current fetch address to the instruction memory.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = if_id_instr is a real fetched instruction; 0 = bubble.

Behaviour:
- Reset (rst=0, asynchronous, at any time including mid-redirect or mid-stall):
  - pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0.
  - Deassertion takes effect at the first posedge with rst=1.
- pc is a register. It drives the memory directly, so instruction is valid in the same cycle. Fetch latency is 1 clk from pc to if_id_instr.
- Per-posedge action, in priority order:
  1. stall=1: pc, if_id_instr, if_id_pc4 and if_id_valid all hold. br_taken is ignored in this cycle; ID re-asserts it after the stall clears.
  2. br_taken=1 (stall=0): pc <= {br_target[31:2],2'b00}, forcing alignment. IF/ID is flushed: if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0. The instruction fetched in this cycle is discarded.
  3. Otherwise: pc <= pc+4; if_id_instr <= instruction; if_id_pc4 <= pc+4; if_id_valid <= 1.
- Arithmetic: pc+4 is 32-bit unsigned and wraps mod 2^32 (32'hFFFF_FFFC -> 0). No error is flagged.
- Back-to-back redirects: each produces one bubble and is taken immediately, with no lockout.
- A redirect to the current pc, as in the JMP -1 idle loop, is legal. It yields a steady flush pattern: valid alternates 1,0 as the JMP is refetched.
- The stage makes no combinational path from stall or br_taken to pc. pc changes only on a clock edge or reset.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined, the stage adds three 32-bit output ports: perf_fetched, perf_stalls and perf_flushes.
  - perf_fetched increments on each case-3 cycle.
  - perf_stalls increments on each stall=1 cycle.
  - perf_flushes increments on each case-2 cycle.
- All three saturate at 32'hFFFF_FFFF and reset to 0 with rst.
- When not defined, the ports and counters do not exist, and the block behaves exactly as above with no extra logic.

Test Plan:
- Reset and sequential fetch: rst=0 for 2 clk, then release; memory words i*16+1. Required: pc=0,4,8,12 on successive cycles; if_id_instr=1,17,33 with if_id_pc4=4,8,12 and valid=1 from the 1st edge onward.
- Stall hold: pc=12, stall=1 for 3 clk. Required: pc stays 12 and IF/ID holds its value for all 3 cycles; on release the next edge gives pc=16 and if_id_pc4=16.
- Redirect and flush: at pc=20, br_taken=1 with br_target=32'h0000_00BE. Required: next pc=0xBC, if_id_instr=0, valid=0; the edge after gives valid=1 with if_id_pc4=0xC0.
- Stall beats branch: stall=1 and br_taken=1 together at pc=40. Required: pc stays 40 and IF/ID holds; with stall=0 and br_taken=1 on the next cycle, pc=br_target.
- Async reset mid-operation: assert rst=0 between edges while pc=0x100. Required: pc=0 and valid=0 immediately, before any clock edge.
- PC wrap and perf counters (IF_FETCH_PERF_EN): redirect to 0xFFFF_FFFC, then one fetch. Required: pc=0 after the fetch and if_id_pc4=0; perf_flushes=1 and perf_fetched=1.
